// File: rtl/stream_feeder_case2_if.sv
// Output stream bundle of the case-2 stream feeder.
// Carries the H-row stream and the alpha column stream toward the decoder.
// The receiver has no ready signal, so the bundle has only valid, last and data.
//   master : driven by the feeder
//   slave  : observed by the decoder (or a bench)
interface stream_feeder_case2_if #(
  parameter int J = 14
);
  logic [J-1:0]   H_row;
  logic           H_row_tvalid;
  logic           H_row_tlast;
  logic [J*8-1:0] alpha_u_col;
  logic           alpha_u_col_tvalid;
  logic           alpha_u_col_tlast;

  modport master (
    output H_row, H_row_tvalid, H_row_tlast,
    output alpha_u_col, alpha_u_col_tvalid, alpha_u_col_tlast
  );

  modport slave (
    input H_row, H_row_tvalid, H_row_tlast,
    input alpha_u_col, alpha_u_col_tvalid, alpha_u_col_tlast
  );
endinterface

// File: rtl/stream_feeder_case2.sv
// Source-side feeder for the case-2 iterative decoder.
// Holds a local H matrix (I rows of J bits) and A initial alpha columns
// (J bytes each), and on command emits them as valid/last streams.
// The receiver cannot stall, so pacing comes from the GAP idle cycles
// inserted between consecutive beats.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cfg_wr_en/sel/addr/wdata  local store write port (sel 0 = H, 1 = alpha)
//   start             full frame: H rows then alpha columns
//   start_alpha_only  frame with alpha columns only
//   busy, done, err   status (done is a one-cycle pulse, err is sticky)
//   feed              H_row and alpha_u_col streams (master side)
module stream_feeder_case2 #(
  parameter int J   = 14,
  parameter int I   = 7,
  parameter int A   = 2,
  parameter int GAP = 0,
  localparam int CW = $clog2((I > A) ? I : A) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_wr_en,
  input  logic                 cfg_sel,
  input  logic [CW-1:0]        cfg_addr,
  input  logic [J*8-1:0]       cfg_wdata,
  input  logic                 start,
  input  logic                 start_alpha_only,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  stream_feeder_case2_if.master feed
);

  localparam int HW = (I > 1) ? $clog2(I) : 1;
  localparam int AW = (A > 1) ? $clog2(A) : 1;
  localparam logic [CW-1:0] H_LAST = CW'(I - 1);
  localparam logic [CW-1:0] A_LAST = CW'(A - 1);
  localparam logic [CW-1:0] H_LIM  = CW'(I);
  localparam logic [CW-1:0] A_LIM  = CW'(A);
  localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND_H   = 3'd1,
    GAP_WAIT = 3'd2,
    SEND_A   = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t         state_r, state_nx;
  logic [CW-1:0]  cnt_r, cnt_nx;
  logic [3:0]     gap_r, gap_nx;
  logic           pend_a_r, pend_a_nx;   // beat waiting behind GAP_WAIT is alpha

  logic [J-1:0]   h_store_r [I];
  logic [J*8-1:0] a_store_r [A];

  logic           cmd_ok_s, cmd_rej_s, addr_ok_s, wr_ok_s, wr_rej_s;
  logic           err_nx;
  logic           h_v_nx, h_l_nx, a_v_nx, a_l_nx, busy_nx, done_nx;
  logic [J-1:0]   h_row_nx;
  logic [J*8-1:0] a_col_nx;

  logic           h_v_r, h_l_r, a_v_r, a_l_r, busy_r, done_r, err_r;
  logic [J-1:0]   h_row_r;
  logic [J*8-1:0] a_col_r;

  // Command/config acceptance: everything is only taken while idle.
  always_comb begin
    addr_ok_s = cfg_sel ? (cfg_addr < A_LIM) : (cfg_addr < H_LIM);
    wr_ok_s   = cfg_wr_en && (state_r == IDLE) && addr_ok_s;
    wr_rej_s  = cfg_wr_en && !wr_ok_s;
    cmd_ok_s  = (start || start_alpha_only) && (state_r == IDLE);
    cmd_rej_s = (start || start_alpha_only) && (state_r != IDLE);
    if (wr_rej_s || cmd_rej_s) begin
      err_nx = 1'b1;             // a rejection beats a same-cycle clear
    end else if (cmd_ok_s) begin
      err_nx = 1'b0;
    end else begin
      err_nx = err_r;
    end
  end

  // Next-state logic; cnt_nx always names the beat that the next state emits.
  always_comb begin
    state_nx  = state_r;
    cnt_nx    = cnt_r;
    gap_nx    = gap_r;
    pend_a_nx = pend_a_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx = SEND_H;
          cnt_nx   = '0;
        end else if (start_alpha_only) begin
          state_nx = SEND_A;
          cnt_nx   = '0;
        end else begin
          state_nx = IDLE;
        end
      end
      SEND_H: begin
        if (cnt_r == H_LAST) begin
          pend_a_nx = 1'b1;
          cnt_nx    = '0;
        end else begin
          pend_a_nx = 1'b0;
          cnt_nx    = cnt_r + CW'(1);
        end
        if (GAP > 0) begin
          state_nx = GAP_WAIT;
          gap_nx   = 4'd0;
        end else begin
          state_nx = (cnt_r == H_LAST) ? SEND_A : SEND_H;
        end
      end
      GAP_WAIT: begin
        if (gap_r == GAP_LAST) begin
          state_nx = pend_a_r ? SEND_A : SEND_H;
        end else begin
          gap_nx = gap_r + 4'd1;
        end
      end
      SEND_A: begin
        if (cnt_r == A_LAST) begin
          state_nx = DONE;       // no gap after the final beat
        end else begin
          cnt_nx    = cnt_r + CW'(1);
          pend_a_nx = 1'b1;
          if (GAP > 0) begin
            state_nx = GAP_WAIT;
            gap_nx   = 4'd0;
          end else begin
            state_nx = SEND_A;
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Output values computed from the next state so they can be registered.
  always_comb begin
    h_v_nx   = (state_nx == SEND_H);
    a_v_nx   = (state_nx == SEND_A);
    h_l_nx   = h_v_nx && (cnt_nx == H_LAST);
    a_l_nx   = a_v_nx && (cnt_nx == A_LAST);
    h_row_nx = h_v_nx ? h_store_r[cnt_nx[HW-1:0]] : '0;
    a_col_nx = a_v_nx ? a_store_r[cnt_nx[AW-1:0]] : '0;
    busy_nx  = (state_nx == SEND_H) || (state_nx == GAP_WAIT) || (state_nx == SEND_A);
    done_nx  = (state_nx == DONE);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      gap_r    <= 4'd0;
      pend_a_r <= 1'b0;
    end else begin
      state_r  <= state_nx;
      cnt_r    <= cnt_nx;
      gap_r    <= gap_nx;
      pend_a_r <= pend_a_nx;
    end
  end

  // Local H / alpha store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < I; r++) h_store_r[r] <= '0;
      for (int c = 0; c < A; c++) a_store_r[c] <= '0;
    end else if (wr_ok_s) begin
      if (cfg_sel) begin
        a_store_r[cfg_addr[AW-1:0]] <= cfg_wdata;
      end else begin
        h_store_r[cfg_addr[HW-1:0]] <= cfg_wdata[J-1:0];
      end
    end else begin
      h_store_r <= h_store_r;
      a_store_r <= a_store_r;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_v_r   <= 1'b0;
      h_l_r   <= 1'b0;
      h_row_r <= '0;
      a_v_r   <= 1'b0;
      a_l_r   <= 1'b0;
      a_col_r <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      h_v_r   <= h_v_nx;
      h_l_r   <= h_l_nx;
      h_row_r <= h_row_nx;
      a_v_r   <= a_v_nx;
      a_l_r   <= a_l_nx;
      a_col_r <= a_col_nx;
      busy_r  <= busy_nx;
      done_r  <= done_nx;
      err_r   <= err_nx;
    end
  end

  assign feed.H_row              = h_row_r;
  assign feed.H_row_tvalid       = h_v_r;
  assign feed.H_row_tlast        = h_l_r;
  assign feed.alpha_u_col        = a_col_r;
  assign feed.alpha_u_col_tvalid = a_v_r;
  assign feed.alpha_u_col_tlast  = a_l_r;
  assign busy = busy_r;
  assign done = done_r;
  assign err  = err_r;

endmodule
